sfq_gate_stim_tx: RTL

SFQ_GATE_STIM_TX -- requirements
Module: sfq_gate_stim_tx

---
 rtl/sfq_tx_pkg.sv | 24 ++
 rtl/sfq_edge_det.sv | 23 ++
 rtl/sfq_gate_stim_tx.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/sfq_tx_pkg.sv
// Shared types and defaults for the SFQ gate stimulus transmitter.
// Optional response checking is enabled by defining SFQ_TX_CHECK_EN.
package sfq_tx_pkg;

    typedef enum logic [2:0] {
        INIT,
        IDLE,
        SETUP,
        WAIT_Q,
        GAP
    } state_e;

    localparam int SETUP_CYC_DEF = 2;
    localparam int Q_WINDOW_DEF  = 8;
    localparam int GAP_CYC_DEF   = 1;

    // Wide enough for the largest Q_WINDOW (255).
    localparam int CNT_W = 8;

    function automatic logic [1:0] sat_inc2(input logic [1:0] c);
        return (c == 2'd2) ? 2'd2 : c + 2'd1;
    endfunction

endpackage

// File: rtl/sfq_edge_det.sv
// Toggle-event detector for a toggle-encoded SFQ line.
// load re-synchronises q_prev without reporting an event.
module sfq_edge_det (
    input  logic clk,
    input  logic rst,
    input  logic sig,
    input  logic load,
    output logic evt
);

    logic q_prev;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q_prev <= 1'b0;
        end else begin
            q_prev <= sig;
        end
    end

    assign evt = (sig ^ q_prev) & ~load;

endmodule

// File: rtl/sfq_gate_stim_tx.sv
// Drives one SFQ gate test vector and captures the gate response.
// Defining SFQ_TX_CHECK_EN adds rsp_mismatch against an OR-gate expectation.
module sfq_gate_stim_tx
    import sfq_tx_pkg::*;
#(
    parameter int SETUP_CYC = SETUP_CYC_DEF,
    parameter int Q_WINDOW  = Q_WINDOW_DEF,
    parameter int GAP_CYC   = GAP_CYC_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic req_valid,
    output logic req_ready,
    input  logic req_a,
    input  logic req_b,
    output logic sfq_a,
    output logic sfq_b,
    output logic sfq_clk,
    input  logic sfq_q,
    output logic rsp_valid,
    output logic rsp_q,
    output logic rsp_err,
`ifdef SFQ_TX_CHECK_EN
    output logic rsp_mismatch,
`endif
    output logic spurious
);

    localparam logic [CNT_W-1:0] SETUP_LAST = CNT_W'(SETUP_CYC);
    localparam logic [CNT_W-1:0] WIN_LAST   = CNT_W'(Q_WINDOW - 1);
    localparam logic [CNT_W-1:0] GAP_LAST   =
        (GAP_CYC > 0) ? CNT_W'(GAP_CYC - 1) : '0;

    state_e state;
    state_e state_nxt;

    logic [CNT_W-1:0] cnt;
    logic [1:0]       ev_cnt;
    logic [1:0]       ev_tot;

    logic evt;
    logic load;
    logic accept;
    logic fire_clk;
    logic fin;
    logic in_win;
    logic spur_evt;

    logic setup_done;
    logic win_done;
    logic gap_done;

    sfq_edge_det u_edge (
        .clk  (clk),
        .rst  (rst),
        .sig  (sfq_q),
        .load (load),
        .evt  (evt)
    );

    assign setup_done = (cnt == SETUP_LAST);
    assign win_done   = (cnt == WIN_LAST);
    assign gap_done   = (cnt == GAP_LAST);

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= INIT;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        unique case (state)
            INIT: begin
                state_nxt = IDLE;
            end
            IDLE: begin
                if (req_valid) begin
                    state_nxt = SETUP;
                end
            end
            SETUP: begin
                if (setup_done) begin
                    state_nxt = WAIT_Q;
                end
            end
            WAIT_Q: begin
                if (win_done) begin
                    state_nxt = (GAP_CYC == 0) ? IDLE : GAP;
                end
            end
            GAP: begin
                if (gap_done) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = INIT;
            end
        endcase
    end

    // Output / control decode
    always_comb begin
        req_ready = (state == IDLE);
        load      = (state == INIT);
        in_win    = (state == WAIT_Q);
        accept    = req_ready && req_valid;
        fire_clk  = (state == SETUP) && setup_done;
        fin       = in_win && win_done;
        spur_evt  = evt && !in_win;
    end

    // An event on the closing window edge still belongs to this response.
    assign ev_tot = (in_win && evt) ? sat_inc2(ev_cnt) : ev_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (state_nxt != state) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sfq_a     <= 1'b0;
            sfq_b     <= 1'b0;
            sfq_clk   <= 1'b0;
            ev_cnt    <= 2'd0;
            rsp_valid <= 1'b0;
            rsp_q     <= 1'b0;
            rsp_err   <= 1'b0;
            spurious  <= 1'b0;
        end else begin
            rsp_valid <= fin;
            if (accept) begin
                sfq_a  <= sfq_a ^ req_a;
                sfq_b  <= sfq_b ^ req_b;
                ev_cnt <= 2'd0;
            end else if (in_win) begin
                ev_cnt <= ev_tot;
            end
            if (fire_clk) begin
                sfq_clk <= ~sfq_clk;
            end
            if (fin) begin
                rsp_q   <= (ev_tot != 2'd0);
                rsp_err <= (ev_tot == 2'd2);
            end
            if (spur_evt) begin
                spurious <= 1'b1;
            end
        end
    end

`ifdef SFQ_TX_CHECK_EN
    logic lat_a;
    logic lat_b;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lat_a        <= 1'b0;
            lat_b        <= 1'b0;
            rsp_mismatch <= 1'b0;
        end else begin
            if (accept) begin
                lat_a <= req_a;
                lat_b <= req_b;
            end
            if (fin) begin
                rsp_mismatch <= (ev_tot != 2'd0) != (lat_a | lat_b);
            end
        end
    end
`endif

endmodule
